detect_stream_ctrl: RTL and testbench



---
 rtl/detect_stream_ctrl_pkg.sv | 20 ++
 rtl/detect_stream_ctrl_if.sv | 12 +
 rtl/detect_stream_ctrl_pattern_matcher.sv | 37 +++
 rtl/detect_stream_ctrl.sv | 121 ++++++++++++
 tb/tb_detect_stream_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/detect_stream_ctrl_pkg.sv
// Shared types and default constants for the word-to-bit pattern detection controller.
package detect_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          DEF_DATA_W    = 8;
  localparam int          DEF_PAT_W     = 3;
  localparam int          DEF_CNT_W     = 8;
  localparam logic [31:0] DEF_PAT_RESET = 32'd3;

  // Width of a bit index into an n-bit word; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/detect_stream_ctrl_if.sv
// Word stream handshake: the producer presents a word plus its end-of-frame flag.
interface detect_stream_ctrl_if #(
  parameter int DATA_W = detect_ctrl_pkg::DEF_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/detect_stream_ctrl_pattern_matcher.sv
// Overlapping serial pattern compare: history register, saturating bits-seen counter and window compare.
// match is combinational and only valid on shift cycles; the caller registers it.
module pattern_matcher
  import detect_ctrl_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             CLOCK,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             clear,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int SEEN_W = $clog2(PAT_W + 1);

  logic [PAT_W-2:0]  hist_q;
  logic [SEEN_W-1:0] seen_q;
  logic [PAT_W-1:0]  window_d;

  // Only PAT_W-1 past bits are kept; the incoming bit completes the window.
  assign window_d = {hist_q, bit_in};
  assign match    = shift_en && (window_d == pattern) && (seen_q >= SEEN_W'(PAT_W - 1));

  always_ff @(posedge CLOCK) begin
    if (reset || clear) begin
      hist_q <= '0;
      seen_q <= '0;
    end else if (shift_en) begin
      hist_q <= window_d[PAT_W-2:0];
      if (seen_q != SEEN_W'(PAT_W)) seen_q <= seen_q + SEEN_W'(1);
    end
  end

endmodule

// File: rtl/detect_stream_ctrl.sv
// Serializes handshaked words one bit per CLOCK into an overlapping pattern matcher, counts matches per frame.
// Define DETECT_CTRL_LSB_FIRST_EN to serialize words LSB first (default MSB first).
module detect_stream_ctrl
  import detect_ctrl_pkg::*;
#(
  parameter int               DATA_W    = DEF_DATA_W,
  parameter int               PAT_W     = DEF_PAT_W,
  parameter int               CNT_W     = DEF_CNT_W,
  parameter logic [PAT_W-1:0] PAT_RESET = DEF_PAT_RESET[PAT_W-1:0]
) (
  input  logic                 CLOCK,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [PAT_W-1:0]     cfg_pattern,
  detect_stream_ctrl_if.slave  in_if,
  output logic                 busy,
  output logic                 bit_out,
  output logic                 match_pulse,
  output logic [CNT_W-1:0]     match_count,
  output logic                 done_pulse
);

  localparam int               IDX_W    = idx_w(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t             state_q;
  logic [DATA_W-1:0]  word_q;
  logic [DATA_W-1:0]  word_d;
  logic               last_q;
  logic [IDX_W-1:0]   bit_idx_q;
  logic               frame_active_q;
  logic [PAT_W-1:0]   pattern_q;
  logic               match_pulse_q;
  logic               done_pulse_q;
  logic [CNT_W-1:0]   match_count_q;
  logic               shift_en;
  logic               accept;
  logic               frame_start;
  logic               match_hit;

  // The latched word shifts so the outgoing bit always sits at a fixed end.
`ifdef DETECT_CTRL_LSB_FIRST_EN
  assign word_d  = {1'b0, word_q[DATA_W-1:1]};
  assign bit_out = shift_en & word_q[0];
`else
  assign word_d  = {word_q[DATA_W-2:0], 1'b0};
  assign bit_out = shift_en & word_q[DATA_W-1];
`endif

  assign shift_en        = (state_q == SHIFT);
  assign in_if.in_ready  = (state_q == IDLE);
  assign accept          = in_if.in_ready & in_if.in_valid;
  assign frame_start     = accept & ~frame_active_q;
  assign busy            = (state_q != IDLE);
  assign match_pulse     = match_pulse_q;
  assign done_pulse      = done_pulse_q;
  assign match_count     = match_count_q;

  pattern_matcher #(.PAT_W(PAT_W)) u_matcher (
    .CLOCK    (CLOCK),
    .reset    (reset),
    .shift_en (shift_en),
    .bit_in   (bit_out),
    .clear    (frame_start),
    .pattern  (pattern_q),
    .match    (match_hit)
  );

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_q        <= IDLE;
      word_q         <= '0;
      last_q         <= 1'b0;
      bit_idx_q      <= '0;
      frame_active_q <= 1'b0;
      pattern_q      <= PAT_RESET;
      match_pulse_q  <= 1'b0;
      done_pulse_q   <= 1'b0;
      match_count_q  <= '0;
    end else begin
      match_pulse_q <= match_hit;
      done_pulse_q  <= 1'b0;
      // match_hit only fires in SHIFT, so this never collides with the frame-start clear.
      if (match_hit && (match_count_q != '1)) match_count_q <= match_count_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          if (cfg_we && !frame_active_q) pattern_q <= cfg_pattern;
          if (accept) begin
            word_q    <= in_if.in_data;
            last_q    <= in_if.in_last;
            bit_idx_q <= '0;
            state_q   <= SHIFT;
            if (frame_start) begin
              match_count_q  <= '0;
              frame_active_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          word_q    <= word_d;
          bit_idx_q <= bit_idx_q + IDX_W'(1);
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_q <= '0;
            if (last_q) begin
              state_q      <= DONE;
              done_pulse_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DONE: begin
          frame_active_q <= 1'b0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_detect_stream_ctrl.sv
// Randomized bench for detect_stream_ctrl; a window-over-bitstream model predicts pulses and counts.
module tb_detect_stream_ctrl;

  localparam int DW = 8;
  localparam int PW = 3;
  localparam logic [PW-1:0] PAT_RST = 3'b011;

  logic          CLOCK = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_we = 1'b0;
  logic [PW-1:0] cfg_pattern = '0;

  always #5 CLOCK = ~CLOCK;

  detect_stream_ctrl_if #(.DATA_W(DW)) bus_a ();
  detect_stream_ctrl_if #(.DATA_W(DW)) bus_b ();

  assign bus_b.in_valid = bus_a.in_valid;
  assign bus_b.in_data  = bus_a.in_data;
  assign bus_b.in_last  = bus_a.in_last;

  logic       busy_a, bit_a, mp_a, dp_a;
  logic [7:0] cnt_a;
  logic       busy_b, bit_b, mp_b, dp_b;
  logic [1:0] cnt_b;

  detect_stream_ctrl #(.DATA_W(DW), .PAT_W(PW), .CNT_W(8), .PAT_RESET(PAT_RST)) dut_a (
    .CLOCK(CLOCK), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .in_if(bus_a),
    .busy(busy_a), .bit_out(bit_a), .match_pulse(mp_a), .match_count(cnt_a), .done_pulse(dp_a));

  detect_stream_ctrl #(.DATA_W(DW), .PAT_W(PW), .CNT_W(2), .PAT_RESET(PAT_RST)) dut_b (
    .CLOCK(CLOCK), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .in_if(bus_b),
    .busy(busy_b), .bit_out(bit_b), .match_pulse(mp_b), .match_count(cnt_b), .done_pulse(dp_b));

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [PW-1:0] pat_m = PAT_RST;
  bit            frame_open = 1'b0;
  int            fbits[$];
  int            mtot = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // True when the newest PW bits of the frame, oldest first, spell the pattern.
  function automatic bit win_match();
    int n = fbits.size();
    int v = 0;
    if (n < PW) return 1'b0;
    for (int i = 0; i < PW; i++) v = (v << 1) | fbits[n - PW + i];
    return v == int'(pat_m);
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_rdy"},   bus_a.in_ready, 1);
    check({tag, "_outs"},  {busy_a, bit_a, mp_a, dp_a, busy_b, dp_b}, 0);
    check({tag, "_cnt_a"}, cnt_a, 0);
    check({tag, "_cnt_b"}, cnt_b, 0);
  endtask

  task automatic write_cfg(input logic [PW-1:0] p);
    cfg_we = 1'b1;
    cfg_pattern = p;
    @(negedge CLOCK);
    cfg_we = 1'b0;
    if (!frame_open) pat_m = p;
  endtask

  // Starts at a negedge; ends at the negedge of the next IDLE cycle.
  task automatic send_word(input logic [DW-1:0] w, input bit last, input int cfg_at,
                           input logic [PW-1:0] cfg_val, input int abort_at);
    logic [DW-1:0] obs_w, exp_w;
    logic [DW:0]   pm_a, pm_b, pe;
    int            t, rdy_hi, dn, busy_n;
    t = 0; rdy_hi = 0; dn = 0; busy_n = 0;
    obs_w = '0; exp_w = '0; pm_a = '0; pm_b = '0; pe = '0;
    while (bus_a.in_ready !== 1'b1 && t < 40) begin
      @(negedge CLOCK);
      t++;
    end
    check("ready_wait", bus_a.in_ready, 1);
    if (!frame_open) begin
      fbits.delete();
      mtot = 0;
      frame_open = 1'b1;
    end
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = w;
    bus_a.in_last  = last;
    @(negedge CLOCK);
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = DW'($urandom);
    bus_a.in_last  = 1'($urandom);
    for (int k = 0; k < DW; k++) begin
      bit eb;
`ifdef DETECT_CTRL_LSB_FIRST_EN
      eb = w[k];
`else
      eb = w[DW-1-k];
`endif
      obs_w[DW-1-k] = bit_a;
      exp_w[DW-1-k] = eb;
      pm_a[k] = mp_a;
      pm_b[k] = mp_b;
      rdy_hi += int'(bus_a.in_ready);
      dn     += int'(dp_a) + int'(dp_b);
      busy_n += int'(busy_a);
      fbits.push_back(int'(eb));
      if (win_match()) begin
        pe[k+1] = 1'b1;
        mtot++;
      end
      if (k == abort_at) begin
        reset = 1'b1;
        cfg_we = 1'b0;
        @(negedge CLOCK);
        check_reset_state("abort");
        reset = 1'b0;
        frame_open = 1'b0;
        pat_m = PAT_RST;
        dn = 0;
        repeat (12) begin
          @(negedge CLOCK);
          dn += int'(dp_a) + int'(dp_b);
        end
        check("abort_no_done", dn, 0);
        return;
      end
      if (k == cfg_at) begin
        cfg_we = 1'b1;
        cfg_pattern = cfg_val;
      end
      @(negedge CLOCK);
      cfg_we = 1'b0;
    end
    pm_a[DW] = mp_a;
    pm_b[DW] = mp_b;
    check("bits",      obs_w, exp_w);
    check("pulse_a",   pm_a, pe);
    check("pulse_b",   pm_b, pe);
    check("shift_rdy", rdy_hi, 0);
    check("shift_bsy", busy_n, DW);
    check("early_dn",  dn, 0);
    check("cnt_a",     cnt_a, imin(mtot, 255));
    check("cnt_b",     cnt_b, imin(mtot, 3));
    check("done_a",    dp_a, last);
    check("done_b",    dp_b, last);
    check("end_rdy",   bus_a.in_ready, !last);
    check("end_busy",  busy_a, last);
    check("end_bit",   bit_a, 0);
    if (last) begin
      @(negedge CLOCK);
      check("post_done", {bus_a.in_ready, busy_a, bit_a, dp_a, mp_a}, 5'b10000);
      frame_open = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = '0;
    bus_a.in_last  = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge CLOCK);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge CLOCK);

    // Pattern 011 on 0110_1100: matches after bits 3 and 6
`ifdef DETECT_CTRL_LSB_FIRST_EN
    send_word(8'b0011_0110, 1'b1, -1, '0, -1);
`else
    send_word(8'b0110_1100, 1'b1, -1, '0, -1);
`endif
    check("tp1_cnt", cnt_a, 2);

    // Match spanning a word boundary
    send_word(8'b1111_1101, 1'b0, -1, '0, -1);
    send_word(8'b1000_0000, 1'b1, -1, '0, -1);
`ifndef DETECT_CTRL_LSB_FIRST_EN
    check("tp2_cnt", cnt_a, 1);
`endif

    // All-ones pattern: 6 matches, narrow counter saturates
    write_cfg(3'b111);
    send_word(8'hFF, 1'b1, -1, '0, -1);
    check("tp3_cnt_a", cnt_a, 6);
    check("tp3_cnt_b", cnt_b, 3);

    // Config write during SHIFT is ignored
    write_cfg(3'b011);
    send_word(8'h00, 1'b1, 3, 3'b000, -1);
    send_word(8'h00, 1'b1, -1, '0, -1);
    check("tp4_cnt", cnt_a, 0);

    // Reset mid-frame, then a fresh frame
    write_cfg(3'b101);
    send_word(8'hA5, 1'b0, -1, '0, 4);
    send_word(8'b0110_1100, 1'b1, -1, '0, -1);

    for (int f = 0; f < 40; f++) begin
      int nw;
      nw = int'($urandom_range(1, 3));
      if ($urandom_range(0, 2) == 0) write_cfg(PW'($urandom));
      for (int i = 0; i < nw; i++) begin
        int ca, ab;
        ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DW - 2)) : -1;
        ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, DW - 1)) : -1;
        if (i > 0 && $urandom_range(0, 3) == 0) write_cfg(PW'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge CLOCK);
        send_word(DW'($urandom), (i == nw - 1), ca, PW'($urandom), ab);
        if (ab >= 0) break;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
